sc_insn_list_unpack: RTL and testbench

- Reads the serialized instruction-info list that the decoder writes, as a byte stream.
- The list holds DEC_INSN_LIST_CAP records of DEC_INSN_INFO_SIZE bytes each.
- Reassembles each record into parallel fields (length, instruction bits, extension, type, disassembly text) and presents one record per valid/ready handshake to the checker/scoreboard side.
- Empty slots (len == 0) are consumed silently. A pulse marks the end of each list.

---
 rtl/sc_insn_list_unpack.sv | 164 ++++++++++++++++
 tb/tb_sc_insn_list_unpack.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_insn_list_unpack.sv
// Unpacks the decoder's serialized instruction-info list (one byte per cycle)
// into parallel record fields, presenting one non-empty record per
// valid/ready handshake and pulsing list_done at the end of every list.
module sc_insn_list_unpack #(
  parameter int INFO_SIZE = 82,
  parameter int LIST_CAP  = 16,
  parameter int LEN_SIZE  = 8,
  parameter int INS_SIZE  = 8,
  parameter int DIS_SIZE  = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [7:0]                      in_data,
  output logic                            rec_valid,
  input  logic                            rec_ready,
  output logic [LEN_SIZE*8-1:0]           rec_len,
  output logic [INS_SIZE*8-1:0]           rec_ins,
  output logic [7:0]                      rec_ext,
  output logic [7:0]                      rec_typ,
  output logic [DIS_SIZE*8-1:0]           rec_dis,
  output logic [$clog2(LIST_CAP)-1:0]     rec_idx,
  output logic                            rec_err,
  output logic                            list_done,
  output logic [$clog2(LIST_CAP+1)-1:0]   rec_count
);

  localparam int OFF_W   = $clog2(INFO_SIZE);
  localparam int SLOT_W  = $clog2(LIST_CAP);
  localparam int CNT_W   = $clog2(LIST_CAP + 1);
  localparam int LEN_W   = LEN_SIZE * 8;
  localparam int INS_W   = INS_SIZE * 8;
  localparam int DIS_W   = DIS_SIZE * 8;
  localparam int INS_OFF = LEN_SIZE;
  localparam int EXT_OFF = INS_OFF + INS_SIZE;
  localparam int TYP_OFF = EXT_OFF + 1;
  localparam int DIS_OFF = TYP_OFF + 1;

  typedef enum logic {ST_FILL = 1'b0, ST_EMIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               list_done_q, list_done_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [INS_W-1:0]   ins_q, ins_d;
  logic [7:0]         ext_q, ext_d;
  logic [7:0]         typ_q, typ_d;
  logic [DIS_W-1:0]   dis_q, dis_d;
  logic               advance_s;

  // Next-state: byte steering into fields, slot resolution, handshake, flush.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    slot_d      = slot_q;
    // The final count stays visible for the list_done cycle, then clears.
    cnt_d       = list_done_q ? {CNT_W{1'b0}} : cnt_q;
    list_done_d = 1'b0;
    len_d       = len_q;
    ins_d       = ins_q;
    ext_d       = ext_q;
    typ_d       = typ_q;
    dis_d       = dis_q;
    advance_s   = 1'b0;
    if (flush) begin
      state_d = ST_FILL;
      off_d   = {OFF_W{1'b0}};
      slot_d  = {SLOT_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_FILL: begin
          if (in_valid) begin
            for (int k = 0; k < LEN_SIZE; k++)
              len_d[8*k +: 8] = (off_q == OFF_W'(k)) ? in_data : len_d[8*k +: 8];
            for (int k = 0; k < INS_SIZE; k++)
              ins_d[8*k +: 8] = (off_q == OFF_W'(INS_OFF + k)) ? in_data : ins_d[8*k +: 8];
            ext_d = (off_q == OFF_W'(EXT_OFF)) ? in_data : ext_q;
            typ_d = (off_q == OFF_W'(TYP_OFF)) ? in_data : typ_q;
            for (int k = 0; k < DIS_SIZE; k++)
              dis_d[8*k +: 8] = (off_q == OFF_W'(DIS_OFF + k)) ? in_data : dis_d[8*k +: 8];
            if (off_q == OFF_W'(INFO_SIZE - 1)) begin
              off_d = {OFF_W{1'b0}};
              // Empty slots are skipped without ever raising rec_valid.
              if (len_d != {LEN_W{1'b0}}) begin
                state_d = ST_EMIT;
              end else begin
                advance_s = 1'b1;
              end
            end else begin
              off_d = off_q + OFF_W'(1);
            end
          end else begin
            off_d = off_q;
          end
        end
        ST_EMIT: begin
          if (rec_ready) begin
            cnt_d     = cnt_q + CNT_W'(1);
            advance_s = 1'b1;
            state_d   = ST_FILL;
          end else begin
            state_d = ST_EMIT;
          end
        end
        default: state_d = ST_FILL;
      endcase
      if (advance_s) begin
        if (slot_q == SLOT_W'(LIST_CAP - 1)) begin
          slot_d      = {SLOT_W{1'b0}};
          list_done_d = 1'b1;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end else begin
        slot_d = slot_d;
      end
    end
  end

  // State and field registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      off_q       <= {OFF_W{1'b0}};
      slot_q      <= {SLOT_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      list_done_q <= 1'b0;
      len_q       <= {LEN_W{1'b0}};
      ins_q       <= {INS_W{1'b0}};
      ext_q       <= 8'h00;
      typ_q       <= 8'h00;
      dis_q       <= {DIS_W{1'b0}};
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      list_done_q <= list_done_d;
      len_q       <= len_d;
      ins_q       <= ins_d;
      ext_q       <= ext_d;
      typ_q       <= typ_d;
      dis_q       <= dis_d;
    end
  end

  assign in_ready  = (state_q == ST_FILL);
  assign rec_valid = (state_q == ST_EMIT);
  assign rec_len   = len_q;
  assign rec_ins   = ins_q;
  assign rec_ext   = ext_q;
  assign rec_typ   = typ_q;
  assign rec_dis   = dis_q;
  assign rec_idx   = slot_q;
  assign rec_err   = (len_q > LEN_W'(INS_SIZE));
  assign list_done = list_done_q;
  assign rec_count = cnt_q;

endmodule

// File: tb/tb_sc_insn_list_unpack.sv
// Randomized bench for sc_insn_list_unpack: lists are built as arrays of
// record structs, serialized to a byte queue, and the expected record and
// list-end sequence is derived from the slot contents.
module tb_sc_insn_list_unpack;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         rec_valid;
  logic         rec_ready = 1'b0;
  logic [63:0]  rec_len;
  logic [63:0]  rec_ins;
  logic [7:0]   rec_ext;
  logic [7:0]   rec_typ;
  logic [511:0] rec_dis;
  logic [3:0]   rec_idx;
  logic         rec_err;
  logic         list_done;
  logic [4:0]   rec_count;

  always #5 clk = ~clk;

  sc_insn_list_unpack dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_len(rec_len), .rec_ins(rec_ins), .rec_ext(rec_ext), .rec_typ(rec_typ),
    .rec_dis(rec_dis), .rec_idx(rec_idx), .rec_err(rec_err),
    .list_done(list_done), .rec_count(rec_count)
  );

  typedef struct {
    logic [63:0]  len;
    logic [63:0]  ins;
    logic [7:0]   ext;
    logic [7:0]   typ;
    logic [511:0] dis;
    logic [3:0]   idx;
  } rec_t;

  rec_t       slots[16];
  rec_t       exp_q[$];
  int         done_q[$];
  logic [7:0] byte_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         prev_done = 1'b0;
  int         done_cycle = -1;

  task automatic check_val(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    int sel = $urandom_range(0, 7);
    if (sel < 2)      r.len = 64'd0;
    else if (sel < 6) r.len = 64'($urandom_range(1, 8));
    else              r.len = {$urandom, $urandom};
    r.ins = {$urandom, $urandom};
    r.ext = 8'($urandom);
    r.typ = 8'($urandom);
    for (int i = 0; i < 16; i++) r.dis[32*i +: 32] = $urandom;
    r.idx = 4'd0;
    return r;
  endfunction

  function automatic logic [7:0] rec_byte(input rec_t r, input int b);
    if (b < 8)        return r.len[8*b +: 8];
    else if (b < 16)  return r.ins[8*(b-8) +: 8];
    else if (b == 16) return r.ext;
    else if (b == 17) return r.typ;
    else              return r.dis[8*(b-18) +: 8];
  endfunction

  // Serialize the first nbytes of the current slot array; derive expectations.
  task automatic load_list(input int nbytes);
    int cnt = 0;
    for (int s = 0; s < 16; s++) begin
      for (int b = 0; b < 82; b++)
        if (s*82 + b < nbytes) byte_q.push_back(rec_byte(slots[s], b));
      if ((s+1)*82 <= nbytes && slots[s].len != 64'd0) begin
        rec_t r = slots[s];
        r.idx = 4'(s);
        exp_q.push_back(r);
        cnt++;
      end
    end
    if (nbytes >= 16*82) done_q.push_back(cnt);
  endtask

  // mode 0: random valid/ready, 1: full speed, 2: hold ready low 20 cycles per record
  task automatic run(input int mode, input int max_cycles);
    int cyc = 0;
    int stall = 0;
    done_cycle = -1;
    while (byte_q.size() != 0 || exp_q.size() != 0 || done_q.size() != 0) begin
      if (cyc >= max_cycles) begin
        check_val("timeout", 512'(byte_q.size() + exp_q.size() + done_q.size()), 512'(0));
        byte_q.delete(); exp_q.delete(); done_q.delete();
        break;
      end
      check_val("in_ready", 512'(in_ready), 512'(!rec_valid));
      if (prev_done) check_val("count_clear", 512'(rec_count), 512'(0));
      prev_done = list_done;
      if (list_done) begin
        if (done_q.size() == 0) check_val("spurious_done", 512'(1), 512'(0));
        else begin
          check_val("done_count", 512'(rec_count), 512'(done_q.pop_front()));
          done_cycle = cyc;
        end
      end
      case (mode)
        0: rec_ready = ($urandom_range(0, 3) != 0);
        1: rec_ready = 1'b1;
        default: begin
          if (rec_valid && stall < 20) begin
            rec_ready = 1'b0;
            stall++;
          end else begin
            rec_ready = 1'b1;
            stall = 0;
          end
        end
      endcase
      if (rec_valid) begin
        if (exp_q.size() == 0) check_val("spurious_rec", 512'(1), 512'(0));
        else begin
          check_val("rec_idx", 512'(rec_idx), 512'(exp_q[0].idx));
          check_val("rec_len", 512'(rec_len), 512'(exp_q[0].len));
          check_val("rec_ins", 512'(rec_ins), 512'(exp_q[0].ins));
          check_val("rec_ext", 512'(rec_ext), 512'(exp_q[0].ext));
          check_val("rec_typ", 512'(rec_typ), 512'(exp_q[0].typ));
          check_val("rec_dis", rec_dis, exp_q[0].dis);
          check_val("rec_err", 512'(rec_err), 512'(exp_q[0].len > 64'd8));
          if (rec_ready) void'(exp_q.pop_front());
        end
      end
      in_valid = (byte_q.size() != 0) && (mode == 1 || $urandom_range(0, 4) != 0);
      in_data  = in_valid ? byte_q[0] : 8'h00;
      if (in_valid && in_ready) void'(byte_q.pop_front());
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    rec_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_in_ready"}, 512'(in_ready), 512'(1));
    check_val({tag, "_rec_valid"}, 512'(rec_valid), 512'(0));
    check_val({tag, "_list_done"}, 512'(list_done), 512'(0));
    check_val({tag, "_rec_count"}, 512'(rec_count), 512'(0));
    check_val({tag, "_rec_idx"}, 512'(rec_idx), 512'(0));
  endtask

  initial begin
    string s = "li a0,10";
    rec_t r;

    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");
    check_val("reset_rec_err", 512'(rec_err), 512'(0));
    check_val("reset_rec_len", 512'(rec_len), 512'(0));
    check_val("reset_rec_dis", rec_dis, 512'(0));

    // Full list at full speed, all slots identical
    r.len = 64'd4; r.ins = 64'h0000_0000_00a0_0513; r.ext = 8'h49; r.typ = 8'h02;
    r.dis = 512'd0; r.idx = 4'd0;
    for (int i = 0; i < 8; i++) r.dis[8*i +: 8] = s[i];
    for (int i = 0; i < 16; i++) slots[i] = r;
    load_list(1312);
    run(1, 3000);
    check_val("full_list_cycles", 512'(done_cycle), 512'(1312 + 16));
    check_val("dis_byte0", 512'(rec_dis[7:0]), 512'(8'h6c));
    check_val("dis_byte7", 512'(rec_dis[63:56]), 512'(8'h30));
    check_val("dis_upper", 512'(rec_dis[511:64]), 512'(0));

    // Empty slots 1, 5 and 15 (slot 15 empty: list ends on its last byte)
    for (int i = 0; i < 16; i++) begin
      slots[i] = rand_rec();
      if (slots[i].len == 64'd0) slots[i].len = 64'd3;
    end
    slots[1].len = 64'd0; slots[5].len = 64'd0; slots[15].len = 64'd0;
    load_list(1312);
    run(0, 6000);

    // Length error boundaries with long back-pressure
    for (int i = 0; i < 16; i++) slots[i] = rand_rec();
    slots[2].len = 64'h0000_0000_0000_000c;
    slots[4].len = 64'h0100_0000_0000_0004;
    slots[6].len = 64'd8;
    slots[7].len = 64'd9;
    slots[8].len = 64'd1;
    load_list(1312);
    run(2, 6000);

    // Flush part-way into slot 3, with a byte offered in the flush cycle
    for (int i = 0; i < 16; i++) slots[i] = rand_rec();
    load_list(3*82 + 40);
    run(0, 3000);
    in_valid = 1'b1; in_data = 8'haa; rec_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; rec_ready = 1'b0;
    check_idle("flush");
    for (int i = 0; i < 16; i++) slots[i] = rand_rec();
    slots[0].len = 64'd5;
    load_list(1312);
    run(0, 6000);

    // Asynchronous reset while a record waits in EMIT
    slots[0] = rand_rec();
    slots[0].len = 64'd4;
    for (int b = 0; b < 82; b++) begin
      in_valid = 1'b1; in_data = rec_byte(slots[0], b);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_val("emit_before_rst", 512'(rec_valid), 512'(1));
    #2 rst = 1'b1;
    #1;
    check_val("rst_rec_valid", 512'(rec_valid), 512'(0));
    check_val("rst_rec_len", 512'(rec_len), 512'(0));
    check_idle("rst");
    @(posedge clk); #1 rst = 1'b0;
    prev_done = 1'b0;

    // Fresh random list after reset
    for (int i = 0; i < 16; i++) slots[i] = rand_rec();
    load_list(1312);
    run(0, 6000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
